ibex_pmp_check_arbiter: RTL and testbench

- Shares one PMP check channel between several requesters (e.g. debug module, DMA shim and the LSU replay path), one check at a time.
- Each request is arbitrated round-robin. Its address, type and privilege are registered and driven onto the PMP channel inputs. The combinational PMP error result is sampled and returned to the winning requester over a held response handshake.
- Sits between the requesters and one channel of ibex_pmp. Also keeps a saturating count of denied checks.

---
 rtl/ibex_pmp_check_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ibex_pmp_check_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pmp_check_arbiter.sv
// ibex_pmp_check_arbiter
// Shares one ibex_pmp check channel between NumReq requesters. Requests are
// granted round-robin, and each winner's address, type and privilege are
// registered and driven to the PMP channel. The PMP error result is latched
// and returned over a held response handshake. A saturating counter tracks
// the number of denied checks.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    per-requester request handshake (ready one-hot, combinational)
//   req_addr/type/priv_i   packed per-requester request payloads
//   csr_update_i           PMP CSR write pulse; discards the current check result
//   pmp_req_*_o            registered request towards the PMP channel
//   pmp_req_err_i          combinational PMP result
//   rsp_valid_o/ready_i    per-requester response handshake (valid one-hot)
//   rsp_err_o              latched denial flag
//   denied_cnt_o           saturating count of denied responses
//   busy_o                 arbiter is not idle
module ibex_pmp_check_arbiter #(
    parameter int unsigned NumReq = 3,
    parameter int unsigned CntW   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumReq-1:0]    req_valid_i,
    output logic [NumReq-1:0]    req_ready_o,
    input  logic [NumReq*34-1:0] req_addr_i,
    input  logic [NumReq*2-1:0]  req_type_i,
    input  logic [NumReq*2-1:0]  req_priv_i,
    input  logic                 csr_update_i,
    output logic [33:0]          pmp_req_addr_o,
    output logic [1:0]           pmp_req_type_o,
    output logic [1:0]           pmp_priv_mode_o,
    input  logic                 pmp_req_err_i,
    output logic [NumReq-1:0]    rsp_valid_o,
    output logic                 rsp_err_o,
    input  logic [NumReq-1:0]    rsp_ready_i,
    output logic [CntW-1:0]      denied_cnt_o,
    output logic                 busy_o
);

    localparam int unsigned AddrW = 34;
    localparam int unsigned PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NumReq-1:0]   gnt_oh_q, gnt_oh_d;
    logic [AddrW-1:0]    addr_q, addr_d;
    logic [1:0]          type_q, type_d;
    logic [1:0]          priv_q, priv_d;
    logic                rsp_err_q, rsp_err_d;
    logic [NumReq-1:0]   rsp_valid_q, rsp_valid_d;
    logic [CntW-1:0]     denied_cnt_q, denied_cnt_d;

    logic                win_found;
    logic [PtrW-1:0]     win_idx;
    logic [NumReq-1:0]   win_oh;

    // Round-robin pick: first pass covers [rr_ptr, NumReq), second pass wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!win_found && req_valid_i[i] && (PtrW'(i) >= rr_ptr_q)) begin
                win_found = 1'b1;
                win_idx   = PtrW'(i);
            end
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!win_found && req_valid_i[i]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(i);
            end
        end
        win_oh = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (win_found && (win_idx == PtrW'(i))) begin
                win_oh[i] = 1'b1;
            end
        end
    end

    // Grant is offered in the same cycle the request is seen, only while idle.
    assign req_ready_o = (!rst_i && (state_q == IDLE)) ? win_oh : '0;

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_oh_d     = gnt_oh_q;
        addr_d       = addr_q;
        type_d       = type_q;
        priv_d       = priv_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = rsp_valid_q;
        denied_cnt_d = denied_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    for (int unsigned i = 0; i < NumReq; i++) begin
                        if (win_oh[i]) begin
                            addr_d = req_addr_i[i*AddrW +: AddrW];
                            type_d = req_type_i[i*2 +: 2];
                            priv_d = req_priv_i[i*2 +: 2];
                        end
                    end
                    gnt_oh_d = win_oh;
                    rr_ptr_d = (win_idx == PtrW'(NumReq - 1)) ? '0 : win_idx + PtrW'(1);
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                // A CSR write makes this cycle's PMP result stale; retry next cycle.
                if (!csr_update_i) begin
                    rsp_err_d   = pmp_req_err_i;
                    rsp_valid_d = gnt_oh_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (|(rsp_ready_i & gnt_oh_q)) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                    if (rsp_err_q && (denied_cnt_q != '1)) begin
                        denied_cnt_d = denied_cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_oh_q     <= '0;
            addr_q       <= '0;
            type_q       <= '0;
            priv_q       <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= '0;
            denied_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_oh_q     <= gnt_oh_d;
            addr_q       <= addr_d;
            type_q       <= type_d;
            priv_q       <= priv_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            denied_cnt_q <= denied_cnt_d;
        end
    end

    assign pmp_req_addr_o  = addr_q;
    assign pmp_req_type_o  = type_q;
    assign pmp_priv_mode_o = priv_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_err_o       = rsp_err_q;
    assign denied_cnt_o    = denied_cnt_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_pmp_check_arbiter.sv
// Testbench for ibex_pmp_check_arbiter (NumReq=3, CntW=2).
// Directed stimulus; expected responses are queued when requests are issued
// and a monitor pops and compares them at every response handshake.
module tb_ibex_pmp_check_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned CW = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NR-1:0]   req_valid_i;
    logic [NR-1:0]   req_ready_o;
    logic [NR*34-1:0] req_addr_i;
    logic [NR*2-1:0] req_type_i;
    logic [NR*2-1:0] req_priv_i;
    logic            csr_update_i;
    logic [33:0]     pmp_req_addr_o;
    logic [1:0]      pmp_req_type_o;
    logic [1:0]      pmp_priv_mode_o;
    logic            pmp_req_err_i;
    logic [NR-1:0]   rsp_valid_o;
    logic            rsp_err_o;
    logic [NR-1:0]   rsp_ready_i;
    logic [CW-1:0]   denied_cnt_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    ibex_pmp_check_arbiter #(.NumReq(NR), .CntW(CW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_type_i      (req_type_i),
        .req_priv_i      (req_priv_i),
        .csr_update_i    (csr_update_i),
        .pmp_req_addr_o  (pmp_req_addr_o),
        .pmp_req_type_o  (pmp_req_type_o),
        .pmp_priv_mode_o (pmp_priv_mode_o),
        .pmp_req_err_i   (pmp_req_err_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_ready_i     (rsp_ready_i),
        .denied_cnt_o    (denied_cnt_o),
        .busy_o          (busy_o)
    );

    typedef struct packed {
        logic [NR-1:0] oh;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [33:0] slot_addr [NR];
    logic [1:0]  slot_type [NR];
    logic [1:0]  slot_priv [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic push(input logic [NR-1:0] oh, input logic err, input logic [CW-1:0] cnt);
        exp_t e;
        e.oh  = oh;
        e.err = err;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Response monitor: every accepted response must match the queue head.
    always @(negedge clk_i) begin
        if (!rst_i && (|(rsp_valid_o & rsp_ready_i))) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_onehot", 64'(rsp_valid_o), 64'(e.oh));
                chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
                chk("rsp_cnt_before", 64'(denied_cnt_o), 64'(e.cnt));
            end
        end
    end

    initial begin
        slot_addr[0] = 34'h0_0000_0100; slot_type[0] = 2'b01; slot_priv[0] = 2'b00;
        slot_addr[1] = 34'h0_0000_1000; slot_type[1] = 2'b10; slot_priv[1] = 2'b11;
        slot_addr[2] = 34'h3_0000_2000; slot_type[2] = 2'b00; slot_priv[2] = 2'b11;
        for (int i = 0; i < int'(NR); i++) begin
            req_addr_i[i*34 +: 34] = slot_addr[i];
            req_type_i[i*2 +: 2]   = slot_type[i];
            req_priv_i[i*2 +: 2]   = slot_priv[i];
        end
        req_valid_i   = '0;
        csr_update_i  = 1'b0;
        pmp_req_err_i = 1'b0;
        rsp_ready_i   = '1;

        // Reset state
        do_reset();
        smp();
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err_o), 64'(0));
        chk("rst_cnt", 64'(denied_cnt_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_pmp_addr", 64'(pmp_req_addr_o), 64'(0));
        chk("rst_pmp_priv", 64'(pmp_priv_mode_o), 64'(0));

        // Single requester, 2-cycle latency
        cyc();
        req_valid_i = 3'b010;
        push(3'b010, 1'b0, 2'd0);
        smp();
        chk("single_grant", 64'(req_ready_o), 64'(3'b010));
        cyc();
        req_valid_i = '0;
        smp();
        chk("single_pmp_addr", 64'(pmp_req_addr_o), 64'(34'h0_0000_1000));
        chk("single_pmp_type", 64'(pmp_req_type_o), 64'(2'b10));
        chk("single_pmp_priv", 64'(pmp_priv_mode_o), 64'(2'b11));
        chk("single_busy", 64'(busy_o), 64'(1));
        chk("single_no_rsp_c1", 64'(rsp_valid_o), 64'(0));
        cyc();
        smp();
        chk("single_rsp_c2", 64'(rsp_valid_o), 64'(3'b010));
        cyc();
        smp();
        chk("single_cnt", 64'(denied_cnt_o), 64'(0));
        chk("single_idle", 64'(busy_o), 64'(0));

        // Round-robin with all three requesters asserting
        do_reset();
        for (int k = 0; k < 6; k++) push(NR'(1) << (k % 3), 1'b0, 2'd0);
        for (int c = 0; c < 18; c++) begin
            cyc();
            if (c == 0) req_valid_i = 3'b111;
            if (c == 16) req_valid_i = '0;
            smp();
            chk("rr_grant", 64'(req_ready_o), (c % 3 == 0) ? 64'(NR'(1) << ((c / 3) % 3)) : 64'(0));
            if (c % 3 == 1) chk("rr_pmp_addr", 64'(pmp_req_addr_o), 64'(slot_addr[(c / 3) % 3]));
        end

        // Denials with 2-bit counter saturation
        for (int k = 0; k < 5; k++) push(3'b001, 1'b1, (k < 3) ? CW'(k) : CW'(3));
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (c == 0) begin
                req_valid_i   = 3'b001;
                pmp_req_err_i = 1'b1;
            end
            if (c == 13) req_valid_i = '0;
            smp();
            if ((c % 3 == 0) && (c > 0)) chk("deny_cnt", 64'(denied_cnt_o), (c / 3 >= 3) ? 64'(3) : 64'(c / 3));
            if (c % 3 == 2) chk("deny_rsp_err", 64'(rsp_err_o), 64'(1));
        end
        pmp_req_err_i = 1'b0;

        // CSR update stretches CHECK; the last CHECK cycle's result is kept
        cyc();
        req_valid_i = 3'b010;
        push(3'b010, 1'b1, 2'd3);
        smp();
        chk("csr_grant", 64'(req_ready_o), 64'(3'b010));
        cyc();
        req_valid_i  = '0;
        csr_update_i = 1'b1;
        smp();
        chk("csr_no_rsp_c1", 64'(rsp_valid_o), 64'(0));
        cyc();
        smp();
        chk("csr_no_rsp_c2", 64'(rsp_valid_o), 64'(0));
        cyc();
        csr_update_i  = 1'b0;
        pmp_req_err_i = 1'b1;
        smp();
        chk("csr_no_rsp_c3", 64'(rsp_valid_o), 64'(0));
        chk("csr_busy_c3", 64'(busy_o), 64'(1));
        cyc();
        csr_update_i  = 1'b1;
        pmp_req_err_i = 1'b0;
        smp();
        chk("csr_rsp_c4", 64'(rsp_valid_o), 64'(3'b010));
        chk("csr_rsp_err", 64'(rsp_err_o), 64'(1));
        cyc();
        csr_update_i = 1'b0;
        smp();
        chk("csr_idle", 64'(busy_o), 64'(0));

        // Response backpressure; winner's ready is the only one that counts
        cyc();
        req_valid_i = 3'b010;
        rsp_ready_i = '0;
        push(3'b010, 1'b1, 2'd3);
        smp();
        chk("bp_grant", 64'(req_ready_o), 64'(3'b010));
        cyc();
        req_valid_i   = 3'b101;
        pmp_req_err_i = 1'b1;
        smp();
        chk("bp_no_grant_check", 64'(req_ready_o), 64'(0));
        for (int c = 2; c < 7; c++) begin
            cyc();
            rsp_ready_i   = 3'b101;
            pmp_req_err_i = 1'b0;
            smp();
            chk("bp_rsp_held", 64'(rsp_valid_o), 64'(3'b010));
            chk("bp_err_stable", 64'(rsp_err_o), 64'(1));
            chk("bp_no_grant", 64'(req_ready_o), 64'(0));
        end
        cyc();
        rsp_ready_i = '1;
        smp();
        chk("bp_no_grant_ack", 64'(req_ready_o), 64'(0));
        cyc();
        push(3'b100, 1'b0, 2'd3);
        smp();
        chk("bp_next_grant", 64'(req_ready_o), 64'(3'b100));
        cyc();
        req_valid_i = '0;
        smp();
        chk("bp_next_addr", 64'(pmp_req_addr_o), 64'(slot_addr[2]));
        cyc();
        smp();
        chk("bp_next_rsp", 64'(rsp_valid_o), 64'(3'b100));
        cyc();

        // Reset during CHECK drops the request
        cyc();
        req_valid_i = 3'b001;
        smp();
        chk("rc_grant", 64'(req_ready_o), 64'(3'b001));
        cyc();
        req_valid_i = '0;
        rst_i       = 1'b1;
        smp();
        chk("rc_ready_in_rst", 64'(req_ready_o), 64'(0));
        cyc();
        rst_i = 1'b0;
        smp();
        chk("rc_busy", 64'(busy_o), 64'(0));
        chk("rc_no_rsp", 64'(rsp_valid_o), 64'(0));
        chk("rc_cnt", 64'(denied_cnt_o), 64'(0));
        cyc();
        smp();
        chk("rc_no_rsp2", 64'(rsp_valid_o), 64'(0));
        cyc();
        req_valid_i = 3'b111;
        push(3'b001, 1'b0, 2'd0);
        smp();
        chk("rc_fresh_grant", 64'(req_ready_o), 64'(3'b001));
        cyc();
        req_valid_i = '0;
        smp();
        chk("rc_pmp_addr", 64'(pmp_req_addr_o), 64'(slot_addr[0]));
        chk("rc_pmp_type", 64'(pmp_req_type_o), 64'(slot_type[0]));
        chk("rc_pmp_priv", 64'(pmp_priv_mode_o), 64'(slot_priv[0]));
        cyc();
        smp();
        chk("rc_rsp", 64'(rsp_valid_o), 64'(3'b001));
        cyc();
        cyc();
        smp();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
